// File: rtl/pll_phase_pkg.sv
// rtl/pll_phase_pkg.sv - shared widths, state encoding and select check for the PLL phase controller
package pll_phase_pkg;

  localparam int SEL_W   = 3;
  localparam int STEPS_W = 8;
  localparam int POS_W   = 12;
  localparam int NUM_OUT = 5;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STEP_LO,
    STEP_HI,
    LOAD,
    WAIT_LOCK
  } state_e;

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(NUM_OUT - 1);

  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return sel <= SEL_MAX;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer bringing the asynchronous PLL lock into clk
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// rtl/pll_phase_ctrl.sv - sequences PHASE_SEL/DIR/STEP_N/LOAD_PHASE strobes for a dynamic PLL phase shift
// Define PLL_PHASE_ACC_EN to add per-output signed phase position tracking on phase_pos.
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int STEP_PULSE   = 2,
  parameter int STEP_GAP     = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [SEL_W-1:0]   req_sel,
  input  logic               req_dir,
  input  logic [STEPS_W-1:0] req_steps,
  input  logic               pll_lock,
  output logic [SEL_W-1:0]   phase_sel,
  output logic               phase_dir,
  output logic               phase_step_n,
  output logic               load_phase,
  output logic               done,
  output logic               err
`ifdef PLL_PHASE_ACC_EN
  ,
  output logic [NUM_OUT*POS_W-1:0] phase_pos
`endif
);

  localparam int CNT_MAX_A = (STEP_PULSE > STEP_GAP) ? STEP_PULSE : STEP_GAP;
  localparam int CNT_MAX   = (LOCK_TIMEOUT > CNT_MAX_A) ? LOCK_TIMEOUT : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(STEP_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STEP_GAP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT);

  logic lock_s;

  pll_lock_sync u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               dir_q, dir_d;
  logic               bad_q, bad_d;
  logic               step_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      dir_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      sel_q   <= sel_d;
      dir_q   <= dir_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    steps_d      = steps_q;
    sel_d        = sel_q;
    dir_d        = dir_q;
    bad_d        = 1'b0;
    step_entry   = 1'b0;
    req_ready    = 1'b0;
    phase_step_n = 1'b1;
    load_phase   = 1'b0;
    done         = 1'b0;
    err          = 1'b0;

    case (state_q)
      IDLE: begin
        // A rejected select is flagged for one cycle, which also masks ready
        req_ready = lock_s & ~bad_q;
        err       = bad_q;
        if (req_valid && lock_s && !bad_q) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          cnt_d   = '0;
          if (sel_valid(req_sel)) begin
            state_d = SETUP;
          end else begin
            bad_d = 1'b1;
          end
        end
      end

      SETUP: begin
        if (!lock_s) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (steps_q == '0) begin
          state_d = LOAD;
        end else begin
          cnt_d      = '0;
          step_entry = 1'b1;
          state_d    = STEP_LO;
        end
      end

      STEP_LO: begin
        // Lock loss releases the strobe combinationally in the same cycle
        if (!lock_s) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          phase_step_n = 1'b0;
          if (cnt_q == PULSE_LAST) begin
            cnt_d   = '0;
            state_d = STEP_HI;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      STEP_HI: begin
        if (!lock_s) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (steps_q == STEPS_W'(1)) begin
            state_d = LOAD;
          end else begin
            steps_d    = steps_q - STEPS_W'(1);
            step_entry = 1'b1;
            state_d    = STEP_LO;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      LOAD: begin
        load_phase = 1'b1;
        cnt_d      = '0;
        state_d    = WAIT_LOCK;
      end

      WAIT_LOCK: begin
        if (lock_s) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err     = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign phase_sel = (state_q == IDLE) ? '0   : sel_q;
  assign phase_dir = (state_q == IDLE) ? 1'b0 : dir_q;

`ifdef PLL_PHASE_ACC_EN
  logic [POS_W-1:0] acc_q [NUM_OUT];
  logic [POS_W-1:0] acc_d [NUM_OUT];
  logic [POS_W-1:0] delta;

  // Retard adds all-ones, i.e. -1 in two's complement
  assign delta = dir_q ? POS_W'(1) : {POS_W{1'b1}};

  always_comb begin
    for (int k = 0; k < NUM_OUT; k++) begin
      acc_d[k] = acc_q[k];
      if (step_entry && (sel_q == SEL_W'(k))) begin
        acc_d[k] = acc_q[k] + delta;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        acc_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        acc_q[k] <= acc_d[k];
      end
    end
  end

  always_comb begin
    phase_pos = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      phase_pos[k*POS_W +: POS_W] = acc_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// tb/tb_pll_phase_ctrl.sv - directed vector bench for pll_phase_ctrl (LOCK_TIMEOUT=16)
module tb_pll_phase_ctrl;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       pll_lock;
  logic [2:0] phase_sel;
  logic       phase_dir;
  logic       phase_step_n;
  logic       load_phase;
  logic       done;
  logic       err;
`ifdef PLL_PHASE_ACC_EN
  logic [59:0] phase_pos;
`endif

  int n_cmp;
  int n_bad;

  pll_phase_ctrl #(
    .STEP_PULSE   (2),
    .STEP_GAP     (4),
    .LOCK_TIMEOUT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .pll_lock     (pll_lock),
    .phase_sel    (phase_sel),
    .phase_dir    (phase_dir),
    .phase_step_n (phase_step_n),
    .load_phase   (load_phase),
    .done         (done),
    .err          (err)
`ifdef PLL_PHASE_ACC_EN
    ,
    .phase_pos    (phase_pos)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic       dir;
    logic [7:0] steps;
    int         drop_at;
    int         exp_lo;
    int         exp_load;
    int         exp_done;
    int         exp_err;
    int         exp_sel1;
    int         exp_rdy2;
  } vec_t;

  vec_t vecs [9];

  int         o_lo, o_load, o_done, o_err, o_nload;
  logic [2:0] o_sel1;
  logic       o_rdy2;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Cycle 0 is the acceptance cycle; cycles 1..40 are sampled at negedge.
  task automatic run_req(input logic [2:0] sel, input logic dir, input logic [7:0] steps,
                         input int drop_at);
    int w;
    o_lo = 0; o_load = -1; o_done = -1; o_err = -1; o_nload = 0;
    o_sel1 = '0; o_rdy2 = 1'b0;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", int'(req_ready), 1);
    req_valid = 1'b1;
    req_sel   = sel;
    req_dir   = dir;
    req_steps = steps;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!phase_step_n) o_lo++;
      if (load_phase) begin
        o_nload++;
        if (o_load < 0) o_load = c;
      end
      if (done && o_done < 0) o_done = c;
      if (err && o_err < 0) o_err = c;
      if (c == 1) o_sel1 = phase_sel;
      if (c == 2) o_rdy2 = req_ready;
      if (c == 1) req_valid = 1'b0;
      if (c == drop_at) pll_lock = 1'b0;
    end
    pll_lock = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_sel   = '0;
    req_dir   = 1'b0;
    req_steps = '0;
    pll_lock  = 1'b1;

    //                sel   dir   steps drop lo load done err sel1 rdy2
    vecs[0] = '{3'd1, 1'b1, 8'd3, -1,  6,  20,  21,  -1,  1,   0};
    vecs[1] = '{3'd2, 1'b0, 8'd0, -1,  0,   2,   3,  -1,  2,   0};
    vecs[2] = '{3'd6, 1'b1, 8'd4, -1,  0,  -1,  -1,   1,  0,   1};
    vecs[3] = '{3'd4, 1'b0, 8'd1, -1,  2,   8,   9,  -1,  4,   0};
    vecs[4] = '{3'd0, 1'b1, 8'd2, -1,  4,  14,  15,  -1,  0,   0};
    vecs[5] = '{3'd3, 1'b1, 8'd5,  7,  3,  -1,  -1,   9,  3,   0};
    vecs[6] = '{3'd2, 1'b1, 8'd0,  1,  0,   2,  -1,  19,  2,   0};
    vecs[7] = '{3'd7, 1'b0, 8'd0, -1,  0,  -1,  -1,   1,  0,   1};
    vecs[8] = '{3'd4, 1'b0, 8'd2, 13,  4,  14,  -1,  31,  4,   0};

    repeat (3) @(negedge clk);
    check("rst_step_n",    int'(phase_step_n), 1);
    check("rst_load",      int'(load_phase),   0);
    check("rst_done",      int'(done),         0);
    check("rst_err",       int'(err),          0);
    check("rst_ready",     int'(req_ready),    0);
    check("rst_phase_sel", int'(phase_sel),    0);
    check("rst_phase_dir", int'(phase_dir),    0);

    rst = 1'b0;
    @(negedge clk);
    check("sync_ready_1cyc", int'(req_ready), 0);
    @(negedge clk);
    check("sync_ready_2cyc", int'(req_ready), 1);

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].sel, vecs[i].dir, vecs[i].steps, vecs[i].drop_at);
      check($sformatf("v%0d_lo_cycles", i), o_lo,          vecs[i].exp_lo);
      check($sformatf("v%0d_load_at", i),   o_load,        vecs[i].exp_load);
      check($sformatf("v%0d_load_cnt", i),  o_nload,       (vecs[i].exp_load >= 0) ? 1 : 0);
      check($sformatf("v%0d_done_at", i),   o_done,        vecs[i].exp_done);
      check($sformatf("v%0d_err_at", i),    o_err,         vecs[i].exp_err);
      check($sformatf("v%0d_sel_c1", i),    int'(o_sel1),  vecs[i].exp_sel1);
      check($sformatf("v%0d_ready_c2", i),  int'(o_rdy2),  vecs[i].exp_rdy2);
    end

    // Asynchronous reset while phase_step_n is low must release it at once.
    begin
      int w;
      w = 0;
      while (!req_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      check("mid_rst_ready_wait", int'(req_ready), 1);
      req_valid = 1'b1;
      req_sel   = 3'd1;
      req_dir   = 1'b1;
      req_steps = 8'd3;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      check("mid_rst_pre_low", int'(phase_step_n), 0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_step_n",    int'(phase_step_n), 1);
      check("mid_rst_phase_sel", int'(phase_sel),    0);
      check("mid_rst_ready",     int'(req_ready),    0);
      @(negedge clk);
      check("mid_rst_load", int'(load_phase), 0);
      rst = 1'b0;
    end

`ifdef PLL_PHASE_ACC_EN
    run_req(3'd0, 1'b1, 8'd3, -1);
    check("acc0_after_plus3", int'(phase_pos[11:0]), 12'h003);
    run_req(3'd0, 1'b0, 8'd5, -1);
    check("acc0_after_minus5", int'(phase_pos[11:0]), 12'hFFE);
    check("acc1_untouched", int'(phase_pos[23:12]), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
